// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and ASCII constants for the UART command parser.
// Optional feature macro: UART_CMD_PARSER_ERR_EN (adds the err_o strobe).
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    TERM = 3'd3,
    DROP = 3'd4
  } parser_state_e;

  // line_err is the combinational "this byte ends a malformed line" flag.
  typedef struct packed {
    parser_state_e state;
    logic          line_err;
  } parser_dbg_t;

  localparam logic [7:0] CHAR_R  = 8'h52;
  localparam logic [7:0] CHAR_W  = 8'h57;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  function automatic logic is_term(input logic [7:0] c);
    return (c == CHAR_CR) || (c == CHAR_LF);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / request-out bundle between the UART receiver, the parser and the bus bridge.
// err_o exists only when UART_CMD_PARSER_ERR_EN is defined.
interface uart_cmd_parser_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  // Handshake: valid_i qualifies data_i for exactly one cycle; valid_o/err_o are
  // one-cycle strobes with no ready, so the consumer must take them when high.
  logic [7:0]            data_i;
  logic                  valid_i;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  rw_o;
  logic                  valid_o;
`ifdef UART_CMD_PARSER_ERR_EN
  logic                  err_o;

  modport master (output data_i, valid_i,
                  input  addr_o, data_o, rw_o, valid_o, err_o);
  modport slave  (input  data_i, valid_i,
                  output addr_o, data_o, rw_o, valid_o, err_o);
`else
  modport master (output data_i, valid_i,
                  input  addr_o, data_o, rw_o, valid_o);
  modport slave  (input  data_i, valid_i,
                  output addr_o, data_o, rw_o, valid_o);
`endif
endinterface

// File: rtl/uart_cmd_parser_hex.sv
// Combinational ASCII hex digit decoder: byte in, nibble plus is_hex flag out.
module ascii_hex_decode (
  input  logic [7:0] data,
  output logic [3:0] nibble,
  output logic       is_hex
);
  always_comb begin
    nibble = '0;
    is_hex = 1'b0;
    if (data >= 8'h30 && data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = data[3:0];
    end else if ((data >= 8'h41 && data <= 8'h46) || (data >= 8'h61 && data <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
      is_hex = 1'b1;
      nibble = data[3:0] + 4'd9;
    end
  end
endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles R<addr> / W<addr><data> lines from UART bytes into register-bus requests.
// Define UART_CMD_PARSER_ERR_EN to get an err_o strobe per discarded line.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  uart_cmd_parser_if.slave    bus,
  output parser_dbg_t         dbg
);
  localparam int ADDR_DIGITS = ADDR_WIDTH / 4;
  localparam int DATA_DIGITS = DATA_WIDTH / 4;
  localparam int MAX_DIGITS  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
  localparam int CNT_W       = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_DIGITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_DIGITS - 1);

  parser_state_e         state_q, state_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_sr_q, addr_sr_d;
  logic [DATA_WIDTH-1:0] data_sr_q, data_sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  issue, error;
  logic [3:0]            nibble;
  logic                  is_hex;
  logic                  term;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rw_out_q;
  logic                  valid_q;

  ascii_hex_decode u_hex (
    .data   (bus.data_i),
    .nibble (nibble),
    .is_hex (is_hex)
  );

  assign term = is_term(bus.data_i);

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    addr_sr_d = addr_sr_q;
    data_sr_d = data_sr_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    error     = 1'b0;
    if (bus.valid_i) begin
      case (state_q)
        IDLE: begin
          if (bus.data_i == CHAR_R || bus.data_i == CHAR_W) begin
            state_d   = ADDR;
            rw_d      = (bus.data_i == CHAR_W);
            addr_sr_d = '0;
            data_sr_d = '0;
            cnt_d     = '0;
          end else if (!term) begin
            state_d = DROP;
          end
        end
        ADDR: begin
          if (is_hex) begin
            addr_sr_d = (addr_sr_q << 4) | ADDR_WIDTH'(nibble);
            if (cnt_q == ADDR_LAST) begin
              cnt_d   = '0;
              state_d = rw_q ? DATA : TERM;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            // short line ends here with an error; any other junk waits for the terminator
            cnt_d   = '0;
            error   = term;
            state_d = term ? IDLE : DROP;
          end
        end
        DATA: begin
          if (is_hex) begin
            data_sr_d = (data_sr_q << 4) | DATA_WIDTH'(nibble);
            if (cnt_q == DATA_LAST) begin
              cnt_d   = '0;
              state_d = TERM;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d   = '0;
            error   = term;
            state_d = term ? IDLE : DROP;
          end
        end
        TERM: begin
          issue   = term;
          state_d = term ? IDLE : DROP;
        end
        DROP: begin
          if (term) begin
            error   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rw_q      <= 1'b0;
      addr_sr_q <= '0;
      data_sr_q <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rw_out_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_sr_q <= addr_sr_d;
      data_sr_q <= data_sr_d;
      cnt_q     <= cnt_d;
      valid_q   <= issue;
      if (issue) begin
        addr_q   <= addr_sr_q;
        data_q   <= data_sr_q;
        rw_out_q <= rw_q;
      end
    end
  end

  assign bus.addr_o  = addr_q;
  assign bus.data_o  = data_q;
  assign bus.rw_o    = rw_out_q;
  assign bus.valid_o = valid_q;

`ifdef UART_CMD_PARSER_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= error;
  end

  assign bus.err_o = err_q;
`endif

  assign dbg.state    = state_q;
  assign dbg.line_err = error;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: command lines in, request/error strobes checked.
module tb_uart_cmd_parser;
  import uart_cmd_parser_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  parser_dbg_t dbg;

  always #5 clk = ~clk;

  uart_cmd_parser_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  uart_cmd_parser #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .dbg (dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  // Monitor: counts strobes and captures the last request, sampled mid-cycle.
  int          valid_seen = 0;
  int          err_seen   = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;
  logic          last_rw   = 1'b0;

  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      valid_seen <= valid_seen + 1;
      last_addr  <= bus.addr_o;
      last_data  <= bus.data_o;
      last_rw    <= bus.rw_o;
    end
`ifdef UART_CMD_PARSER_ERR_EN
    if (bus.err_o === 1'b1) err_seen <= err_seen + 1;
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.data_i  = b;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    idle(3);
    if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
    n_vec++;
    if (bus.addr_o !== 16'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0000", bus.addr_o); end
    n_vec++;
    if (bus.data_o !== 16'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0000", bus.data_o); end
    n_vec++;
    if (bus.rw_o !== 1'b0) begin n_err++; $display("FAIL reset_rw got=%b exp=0", bus.rw_o); end
    n_vec++;
    if (dbg.state !== IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", dbg.state, IDLE); end
    n_vec++;
`ifdef UART_CMD_PARSER_ERR_EN
    if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
    n_vec++;
`endif
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_read();
    int v0 = valid_seen;
    int e0 = err_seen;
    send_str("R1234", 1);
    send_byte(CHAR_CR, 1);
    send_byte(CHAR_LF, 1);
    idle(4);
    if (valid_seen - v0 !== 1) begin n_err++; $display("FAIL read_count got=%0d exp=1", valid_seen - v0); end
    n_vec++;
    if (last_addr !== 16'h1234) begin n_err++; $display("FAIL read_addr got=%h exp=1234", last_addr); end
    n_vec++;
    if (last_data !== 16'h0000) begin n_err++; $display("FAIL read_data got=%h exp=0000", last_data); end
    n_vec++;
    if (last_rw !== 1'b0) begin n_err++; $display("FAIL read_rw got=%b exp=0", last_rw); end
    n_vec++;
    if (bus.addr_o !== 16'h1234) begin n_err++; $display("FAIL read_addr_hold got=%h exp=1234", bus.addr_o); end
    n_vec++;
    if (err_seen - e0 !== 0) begin n_err++; $display("FAIL read_no_err got=%0d exp=0", err_seen - e0); end
    n_vec++;
  endtask

  task automatic test_write();
    int v0 = valid_seen;
    send_str("WBEEFcafe", 1);
    send_byte(CHAR_LF, 1);
    idle(4);
    if (valid_seen - v0 !== 1) begin n_err++; $display("FAIL write_count got=%0d exp=1", valid_seen - v0); end
    n_vec++;
    if (last_addr !== 16'hBEEF) begin n_err++; $display("FAIL write_addr got=%h exp=beef", last_addr); end
    n_vec++;
    if (last_data !== 16'hCAFE) begin n_err++; $display("FAIL write_data got=%h exp=cafe", last_data); end
    n_vec++;
    if (last_rw !== 1'b1) begin n_err++; $display("FAIL write_rw got=%b exp=1", last_rw); end
    n_vec++;
  endtask

  task automatic test_short_line();
    int v0 = valid_seen;
    int e0 = err_seen;
    send_str("R12", 1);
    send_byte(CHAR_CR, 0);
    // one cycle after the terminator's valid_i cycle
    if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL short_valid got=%b exp=0", bus.valid_o); end
    n_vec++;
`ifdef UART_CMD_PARSER_ERR_EN
    if (bus.err_o !== 1'b1) begin n_err++; $display("FAIL short_err_pulse got=%b exp=1", bus.err_o); end
    n_vec++;
    idle(1);
    if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL short_err_fall got=%b exp=0", bus.err_o); end
    n_vec++;
`endif
    idle(3);
    if (valid_seen - v0 !== 0) begin n_err++; $display("FAIL short_count got=%0d exp=0", valid_seen - v0); end
    n_vec++;
`ifdef UART_CMD_PARSER_ERR_EN
    if (err_seen - e0 !== 1) begin n_err++; $display("FAIL short_err_count got=%0d exp=1", err_seen - e0); end
    n_vec++;
`endif
    v0 = valid_seen;
    send_str("R0001", 1);
    send_byte(CHAR_CR, 1);
    idle(3);
    if (valid_seen - v0 !== 1) begin n_err++; $display("FAIL recover_count got=%0d exp=1", valid_seen - v0); end
    n_vec++;
    if (last_addr !== 16'h0001) begin n_err++; $display("FAIL recover_addr got=%h exp=0001", last_addr); end
    n_vec++;
  endtask

  task automatic test_bad_lines();
    int v0 = valid_seen;
    int e0 = err_seen;
    send_str("R12G4", 1);
    send_byte(CHAR_CR, 1);
    send_str("R12345", 1);
    send_byte(CHAR_CR, 1);
    send_str("r1234", 1);
    send_byte(CHAR_CR, 1);
    idle(3);
    if (valid_seen - v0 !== 0) begin n_err++; $display("FAIL bad_count got=%0d exp=0", valid_seen - v0); end
    n_vec++;
`ifdef UART_CMD_PARSER_ERR_EN
    if (err_seen - e0 !== 3) begin n_err++; $display("FAIL bad_err_count got=%0d exp=3", err_seen - e0); end
    n_vec++;
`endif
    if (dbg.state !== IDLE) begin n_err++; $display("FAIL bad_state got=%0d exp=%0d", dbg.state, IDLE); end
    n_vec++;
  endtask

  task automatic test_reset_mid_line();
    int v0 = valid_seen;
    int e0 = err_seen;
    send_str("W00", 1);
    rst = 1'b1;
    idle(1);
    if (dbg.state !== IDLE) begin n_err++; $display("FAIL midrst_state got=%0d exp=%0d", dbg.state, IDLE); end
    n_vec++;
    rst = 1'b0;
    idle(1);
    send_str("R00FF", 1);
    send_byte(CHAR_CR, 1);
    idle(3);
    if (valid_seen - v0 !== 1) begin n_err++; $display("FAIL midrst_count got=%0d exp=1", valid_seen - v0); end
    n_vec++;
    if (last_addr !== 16'h00FF) begin n_err++; $display("FAIL midrst_addr got=%h exp=00ff", last_addr); end
    n_vec++;
    if (last_rw !== 1'b0) begin n_err++; $display("FAIL midrst_rw got=%b exp=0", last_rw); end
    n_vec++;
    if (last_data !== 16'h0000) begin n_err++; $display("FAIL midrst_data got=%h exp=0000", last_data); end
    n_vec++;
    if (err_seen - e0 !== 0) begin n_err++; $display("FAIL midrst_no_err got=%0d exp=0", err_seen - e0); end
    n_vec++;
  endtask

  task automatic test_back_to_back();
    send_str("W0010ABCD", 0);
    send_byte(CHAR_CR, 0);
    if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid got=%b exp=1", bus.valid_o); end
    n_vec++;
    if (bus.addr_o !== 16'h0010) begin n_err++; $display("FAIL b2b_addr got=%h exp=0010", bus.addr_o); end
    n_vec++;
    if (bus.data_o !== 16'hABCD) begin n_err++; $display("FAIL b2b_data got=%h exp=abcd", bus.data_o); end
    n_vec++;
    if (bus.rw_o !== 1'b1) begin n_err++; $display("FAIL b2b_rw got=%b exp=1", bus.rw_o); end
    n_vec++;
    idle(1);
    if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_valid_fall got=%b exp=0", bus.valid_o); end
    n_vec++;
    if (bus.data_o !== 16'hABCD) begin n_err++; $display("FAIL b2b_data_hold got=%h exp=abcd", bus.data_o); end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_short_line();
    test_bad_lines();
    test_reset_mid_line();
    test_back_to_back();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Converts the byte stream from the UART receiver into bus transactions for the core's register bus. Consumes one ASCII byte per `valid_i` strobe, assembles `R<addr>` read and `W<addr><data>` write commands terminated by CR or LF, and emits one decoded request per well-formed line. Sits between the UART receiver and the bus bridge; malformed lines are discarded without issuing a transaction.

## Interface
- `ADDR_WIDTH`, 16, address bits; multiple of 4; hex digits expected = ADDR_WIDTH/4
- `DATA_WIDTH`, 16, write-data bits; multiple of 4; hex digits expected = DATA_WIDTH/4
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `data_i`  in  8  received byte
- `valid_i`  in  1  one-cycle strobe; `data_i` valid this cycle
- `addr_o`  out  ADDR_WIDTH  decoded address
- `data_o`  out  DATA_WIDTH  decoded write data (0 for reads)
- `rw_o`  out  1  1 = write, 0 = read
- `valid_o`  out  1  one-cycle request strobe
- `err_o`  out  1  one-cycle malformed-line strobe (only with `UART_CMD_PARSER_ERR_EN`)

## Operation
- States: IDLE, ADDR, DATA, TERM, DROP. Transitions occur only on cycles with `valid_i`=1.
- IDLE: 'R' (0x52) -> ADDR, rw=0; 'W' (0x57) -> ADDR, rw=1; clear addr/data shift registers and nibble counter. CR (0x0D)/LF (0x0A) ignored (CRLF and blank lines legal). Any other byte -> DROP.
- ADDR: hex digit shifts into address LSB end (first digit = MS nibble). After ADDR_WIDTH/4 digits: write -> DATA, read -> TERM. Non-hex, non-terminator -> DROP. Terminator before digit count reached -> error, IDLE.
- DATA: same rules for DATA_WIDTH/4 digits, then -> TERM.
- TERM: CR/LF -> issue request, IDLE. Anything else -> DROP (overlong line).
- DROP: discard bytes until CR/LF, then error, IDLE.
- Hex set: '0'-'9', 'A'-'F', 'a'-'f'; case-insensitive for digits only; command letters uppercase only.
- Nibble counter width $clog2(max(ADDR_WIDTH,DATA_WIDTH)/4 + 1); reset to 0 on every phase change.
- "Error" = pulse `err_o` if enabled; otherwise silent. An error never produces `valid_o`.

## Timing
- Reset: state IDLE; `addr_o`, `data_o`, `rw_o`, `valid_o`, `err_o`, counters, shift registers all 0.
- `valid_o` asserts exactly 1 cycle after the terminator's `valid_i` cycle, for 1 cycle. `addr_o`/`data_o`/`rw_o` registered with it and held stable until the next request.
- `err_o` likewise 1 cycle after the offending terminator byte.
- No backpressure: downstream must accept `valid_o` in the cycle it is high.
- Back-to-back `valid_i` on consecutive cycles supported; 1 byte/cycle throughput.
- `rst` mid-line: immediate return to IDLE, partial command lost, no strobe.
- `valid_i` low: state and outputs hold (except strobes, which fall).

## Configuration
- `UART_CMD_PARSER_ERR_EN` defined: `err_o` port exists and pulses per discarded line (short line, bad character, overlong line).
- Undefined: `err_o` port absent; malformed lines dropped silently; state machine otherwise identical.

## Structure
- Package `uart_cmd_parser_pkg`: state enum (IDLE/ADDR/DATA/TERM/DROP), ASCII constants (CHAR_R, CHAR_W, CHAR_CR, CHAR_LF).
- Sub-module `ascii_hex_decode`: combinational, byte in -> 4-bit nibble + `is_hex` flag; instantiated once.
- Top holds FSM, shift registers, nibble counter, output registers.

## Test plan
- "R1234\r\n" -> one `valid_o`, `rw_o`=0, `addr_o`=0x1234, `data_o`=0; LF after CR ignored, no second strobe.
- "WBEEFcafe\n" -> `valid_o`, `rw_o`=1, `addr_o`=0xBEEF, `data_o`=0xCAFE.
- "R12\r" -> no `valid_o`; `err_o` pulse 1 cycle after CR (macro on); next "R0001\r" decodes 0x0001.
- "R12G4\r" and "R12345\r" -> each one `err_o`, no `valid_o`.
- Assert `rst` after "W00" then send "R00FF\r" -> single read, `addr_o`=0x00FF, `rw_o`=0.
- Bytes of "W0010ABCD\r" on consecutive cycles -> `valid_o` 1 cycle after CR, `addr_o`=0x0010, `data_o`=0xABCD.
